complex_mac_stream: RTL

Parametrised fixed-point complex multiply-accumulate engine; the next generation of the team's complex multiplier. Accepts a stream of operand pairs (a, b) over a stb/ack handshake, computes the sum over LEN pairs of a·b or a·conj(b), and returns one complex result. It is the inner-product building block for matrix-multiply rows, replacing per-element complex multiplies followed by external adders.

---
 rtl/complex_mac_pkg.sv | 24 ++
 rtl/cplx_prod_stage.sv | 46 ++++
 rtl/complex_mac_stream.sv | 139 +++++++++++++
 3 files changed

// File: rtl/complex_mac_pkg.sv
// rtl/complex_mac_pkg.sv - shared types, width helpers and overflow test for the complex MAC engine
package complex_mac_pkg;

    typedef enum logic [1:0] {
        GET_PAIR = 2'd0,
        MULT     = 2'd1,
        ACCUM    = 2'd2,
        PUT_Z    = 2'd3
    } mac_state_t;

    function automatic int calc_aw(input int width, input int guard);
        return 2 * width + 1 + guard;
    endfunction

    function automatic int calc_lw(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // Two's-complement add wrapped iff both operands share a sign the sum does not.
    function automatic logic add_ovf(input logic a_sign, input logic b_sign, input logic s_sign);
        return (a_sign == b_sign) && (s_sign != a_sign);
    endfunction

endpackage

// File: rtl/cplx_prod_stage.sv
// rtl/cplx_prod_stage.sv - registered complex product with conj-selectable combine
module cplx_prod_stage #(
    parameter int WIDTH = 32,
    localparam int PW = 2 * WIDTH + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    conj,
    input  logic signed [WIDTH-1:0] a_real,
    input  logic signed [WIDTH-1:0] a_imag,
    input  logic signed [WIDTH-1:0] b_real,
    input  logic signed [WIDTH-1:0] b_imag,
    output logic signed [PW-1:0]    p_real,
    output logic signed [PW-1:0]    p_imag
);

    localparam int MW = 2 * WIDTH;

    logic signed [MW-1:0] rr, ii, ri, ir;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr <= '0;
            ii <= '0;
            ri <= '0;
            ir <= '0;
        end else if (en) begin
            rr <= MW'(a_real) * MW'(b_real);
            ii <= MW'(a_imag) * MW'(b_imag);
            ri <= MW'(a_real) * MW'(b_imag);
            ir <= MW'(a_imag) * MW'(b_real);
        end
    end

    // One extra bit keeps rr-ii and ri+ir exact for every operand combination.
    always_comb begin
        p_real = PW'(rr) - PW'(ii);
        p_imag = PW'(ri) + PW'(ir);
        if (conj) begin
            p_real = PW'(rr) + PW'(ii);
            p_imag = PW'(ir) - PW'(ri);
        end
    end

endmodule

// File: rtl/complex_mac_stream.sv
// rtl/complex_mac_stream.sv - streaming complex dot-product engine with stb/ack handshakes
module complex_mac_stream
    import complex_mac_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int GUARD   = 4,
    parameter int MAX_LEN = 16,
    localparam int AW = calc_aw(WIDTH, GUARD),
    localparam int LW = calc_lw(MAX_LEN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] in_a_real,
    input  logic signed [WIDTH-1:0] in_a_imag,
    input  logic signed [WIDTH-1:0] in_b_real,
    input  logic signed [WIDTH-1:0] in_b_imag,
    input  logic [LW-1:0]           in_len,
    input  logic                    in_conj,
    input  logic                    in_stb,
    output logic                    in_ack,
    output logic signed [AW-1:0]    out_z_real,
    output logic signed [AW-1:0]    out_z_imag,
    output logic                    out_ovf,
    output logic                    out_stb,
    input  logic                    out_ack
);

    localparam int PW = 2 * WIDTH + 1;

    mac_state_t state, state_nxt;

    logic [LW-1:0]           count, len_q;
    logic                    conj_q;
    logic signed [WIDTH-1:0] ar_q, ai_q, br_q, bi_q;
    logic signed [PW-1:0]    p_real, p_imag;
    logic signed [AW-1:0]    acc_real, acc_imag;
    logic signed [AW-1:0]    term_real, term_imag;
    logic signed [AW-1:0]    sum_real, sum_imag;
    logic                    ovf_acc, ovf_real, ovf_imag;
    logic                    take_in, take_out, last_term;

    cplx_prod_stage #(.WIDTH(WIDTH)) u_prod (
        .clk    (clk),
        .rst    (rst),
        .en     (state == MULT),
        .conj   (conj_q),
        .a_real (ar_q),
        .a_imag (ai_q),
        .b_real (br_q),
        .b_imag (bi_q),
        .p_real (p_real),
        .p_imag (p_imag)
    );

    assign take_in   = (state == GET_PAIR) && in_ack && in_stb;
    assign take_out  = (state == PUT_Z) && out_stb && out_ack;
    assign last_term = (count + LW'(1)) == len_q;

    assign term_real = AW'(p_real);
    assign term_imag = AW'(p_imag);
    assign sum_real  = acc_real + term_real;
    assign sum_imag  = acc_imag + term_imag;
    assign ovf_real  = add_ovf(acc_real[AW-1], term_real[AW-1], sum_real[AW-1]);
    assign ovf_imag  = add_ovf(acc_imag[AW-1], term_imag[AW-1], sum_imag[AW-1]);

    always_comb begin
        state_nxt = state;
        unique case (state)
            GET_PAIR: if (take_in) state_nxt = MULT;
            MULT:     state_nxt = ACCUM;
            ACCUM:    state_nxt = last_term ? PUT_Z : GET_PAIR;
            PUT_Z:    if (take_out) state_nxt = GET_PAIR;
            default:  state_nxt = GET_PAIR;
        endcase
    end

    // Handshake flags are registered from the next state so they track it without combinational paths.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= GET_PAIR;
            in_ack     <= 1'b0;
            out_stb    <= 1'b0;
            count      <= '0;
            len_q      <= LW'(1);
            conj_q     <= 1'b0;
            ar_q       <= '0;
            ai_q       <= '0;
            br_q       <= '0;
            bi_q       <= '0;
            acc_real   <= '0;
            acc_imag   <= '0;
            ovf_acc    <= 1'b0;
            out_z_real <= '0;
            out_z_imag <= '0;
            out_ovf    <= 1'b0;
        end else begin
            state   <= state_nxt;
            in_ack  <= (state_nxt == GET_PAIR);
            out_stb <= (state_nxt == PUT_Z);

            if (take_in) begin
                ar_q <= in_a_real;
                ai_q <= in_a_imag;
                br_q <= in_b_real;
                bi_q <= in_b_imag;
                if (count == '0) begin
                    conj_q   <= in_conj;
                    acc_real <= '0;
                    acc_imag <= '0;
                    ovf_acc  <= 1'b0;
                    if (in_len == '0)
                        len_q <= LW'(1);
                    else if (in_len > LW'(MAX_LEN))
                        len_q <= LW'(MAX_LEN);
                    else
                        len_q <= in_len;
                end
            end

            if (state == ACCUM) begin
                acc_real <= sum_real;
                acc_imag <= sum_imag;
                count    <= count + LW'(1);
                if (ovf_real || ovf_imag)
                    ovf_acc <= 1'b1;
                // Result registers are separate so they survive the next dot product clearing acc.
                if (last_term) begin
                    out_z_real <= sum_real;
                    out_z_imag <= sum_imag;
                    out_ovf    <= ovf_acc | ovf_real | ovf_imag;
                end
            end

            if (take_out)
                count <= '0;
        end
    end

endmodule
